cam_stream_gen: RTL and testbench
=================================

Name: cam_stream_gen

Overview:
- Synthesizable OV7670-style camera source that emulates the sensor side of the capture interface on one pixel clock.
- Drives vsync/href/px_data using the same framing and RGB565 two-bytes-per-pixel order that the capture block consumes, with a selectable test pattern.
- Used in simulation and on-board self-test to feed the capture path and frame buffer without a physical camera.

Parameters:
- H_ACTIVE, 160, active pixels per line; each pixel takes 2 pclk cycles, so a line has 2*H_ACTIVE data cycles. Range 1..511.
- V_ACTIVE, 120, active lines per frame. Range 1..1023.
- H_BLANK, 144, cycles with href low after each line's data. Range >= 1.
- VSYNC_LINES, 3, line periods with vsync high at frame start. Range >= 1.
- V_BACK, 17, line periods after vsync with href low. Range >= 0.
- V_FRONT, 10, line periods after the last active line with href low. Range >= 1.
- Line period LP = 2*H_ACTIVE + H_BLANK cycles.

Ports:
- pclk  in  1  pixel clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  frame enable; sampled only in IDLE and on the last cycle of V_FRONT.
- pattern_sel  in  2  test pattern select; latched when a frame starts.
- vsync  out  1  frame sync; registered, high during VSYNC_LINES*LP cycles.
- href  out  1  line valid; registered, high during active byte cycles only.
- px_data  out  8  pixel byte; registered; 0x00 whenever href=0.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.
- frame_cnt  out  8  completed-frame count; wraps 255->0.

Behaviour:
- Reset (rst=1 at an edge): next cycle vsync=0, href=0, px_data=0x00, frame_done=0, frame_cnt=0, and state=IDLE. All counters clear. Reset mid-frame aborts the frame immediately, with no frame_done pulse.
- Output timing: all outputs come from registers. State and counter changes show on the outputs in the same cycle the state is entered.
- States and transitions:
  - IDLE: outputs low. If en=1, latch pattern_sel into psel and enter VSYNC next cycle.
  - VSYNC: vsync=1 for VSYNC_LINES*LP cycles, then V_BACK, or LINE if V_BACK=0.
  - V_BACK: V_BACK*LP cycles with vsync=0 and href=0, then LINE with y=0.
  - LINE: href=1 for 2*H_ACTIVE cycles, byte index b=0..2*H_ACTIVE-1, pixel x=b>>1, phase=b[0]. Then HBLANK.
  - HBLANK: H_BLANK cycles. If y<V_ACTIVE-1, then y++ and back to LINE; otherwise V_FRONT.
  - V_FRONT: V_FRONT*LP cycles. On its final cycle: frame_done=1, frame_cnt++, and sample en. If en=1, latch pattern_sel and go to VSYNC; otherwise go to IDLE.
- Frame length is (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)*LP cycles. Back-to-back frames have no gap cycle.
- Pixel colour: 16-bit RGB565 value {R[4:0],G[5:0],B[4:0]}.
  - phase 0 byte = {R[4:0],G[5:3]}.
  - phase 1 byte = {G[2:0],B[4:0]}.
- Patterns, using psel and x/y of the current pixel (counters 10 bits wide):
  - 0, colour bars: bar=x[6:4]. R=bar[2]?31:0, G=bar[1]?63:0, B=bar[0]?31:0.
  - 1, gradient: R=x[4:0], G=y[5:0], B=0.
  - 2, checkerboard: x[3]^y[3] gives 0xFFFF, otherwise 0x0000.
  - 3, frame id: phase 0 byte=frame_cnt, phase 1 byte=~frame_cnt (value at frame start).
- Input changes mid-frame: en and pattern_sel are ignored; the frame always completes with the latched psel.
- frame_cnt is stable during a frame and updates in the same cycle frame_done is high.

Test Plan:
1. Small params (H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, LP=11) with rst then en=1 held → vsync high for exactly 11 cycles, href pulses of exactly 8 cycles separated by 3 low cycles, exactly 2 href pulses per frame, frame_done every 55 cycles, frame_cnt 0→1→2.
2. Same params, pattern 1 → line y=0 bytes 00 00 08 00 10 00 18 00; line y=1 bytes 00 20 08 20 10 20 18 20.
3. Default params, pattern 0 → x=0 gives 00 00; x=16 gives 00 1F; x=64 gives F8 00; x=112 gives FF FF; x=144 gives 00 1F. Also check 320 href-high cycles per line and 120 lines per frame.
4. Pattern 3, third frame after enable → every active pixel is 02 FD; pattern_sel changed to 1 mid-frame has no effect until the next frame.
5. en dropped mid-frame → frame completes, frame_done pulses, then IDLE with all outputs 0. Raising en again → vsync=1 on the next cycle.
6. rst asserted during LINE → next cycle vsync=href=0, px_data=00, frame_cnt=00, and no frame_done pulse.

Source files
------------

// File: rtl/cam_stream_gen_if.sv
// rtl/cam_stream_gen_if.sv - camera-side sync, pixel byte and frame status signals
interface cam_stream_gen_if;
  logic       vsync;
  logic       href;
  logic [7:0] px_data;
  logic       frame_done;
  logic [7:0] frame_cnt;

  modport master (output vsync, href, px_data, frame_done, frame_cnt);
  modport slave  (input  vsync, href, px_data, frame_done, frame_cnt);
endinterface

// File: rtl/cam_stream_gen.sv
// rtl/cam_stream_gen.sv - OV7670-style frame timing and RGB565 test-pattern source
module cam_stream_gen #(
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 120,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       pattern_sel,
  cam_stream_gen_if.master cam
);
  localparam int LP = 2 * H_ACTIVE + H_BLANK;

  // Terminal counts per phase; VB_LAST is never reached when V_BACK is 0.
  localparam logic [31:0] VS_LAST = 32'(VSYNC_LINES * LP - 1);
  localparam logic [31:0] VB_LAST = 32'(V_BACK * LP - 1);
  localparam logic [31:0] VF_LAST = 32'(V_FRONT * LP - 1);
  localparam logic [31:0] LN_LAST = 32'(2 * H_ACTIVE - 1);
  localparam logic [31:0] HB_LAST = 32'(H_BLANK - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_LINE   = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  localparam logic [2:0] S_VFRONT = 3'd5;

  logic [2:0]  state, n_state;
  logic [31:0] cnt, n_cnt;
  logic [9:0]  y, n_y;
  logic [1:0]  psel, n_psel;
  logic [7:0]  frame_cnt_q;
  logic [15:0] rgb;
  logic [7:0]  n_px;
  logic        n_last;

  assign cam.frame_cnt = frame_cnt_q;

  // Outputs are registered from the next-state view so they line up with the state being entered.
  assign n_last = (n_state == S_VFRONT) && (n_cnt == VF_LAST);

  // Frame sequencer: phase transitions, cycle counter within the phase, line index.
  always_comb begin
    n_state = state;
    n_cnt   = cnt + 32'd1;
    n_y     = y;
    n_psel  = psel;
    case (state)
      S_IDLE: begin
        n_cnt = '0;
        if (en) begin
          n_state = S_VSYNC;
          n_psel  = pattern_sel;
        end
      end
      S_VSYNC: begin
        if (cnt == VS_LAST) begin
          n_cnt   = '0;
          n_y     = '0;
          n_state = (V_BACK == 0) ? S_LINE : S_VBACK;
        end
      end
      S_VBACK: begin
        if (cnt == VB_LAST) begin
          n_cnt   = '0;
          n_y     = '0;
          n_state = S_LINE;
        end
      end
      S_LINE: begin
        if (cnt == LN_LAST) begin
          n_cnt   = '0;
          n_state = S_HBLANK;
        end
      end
      S_HBLANK: begin
        if (cnt == HB_LAST) begin
          n_cnt = '0;
          if (y < Y_LAST) begin
            n_y     = y + 10'd1;
            n_state = S_LINE;
          end else begin
            n_state = S_VFRONT;
          end
        end
      end
      S_VFRONT: begin
        if (cnt == VF_LAST) begin
          n_cnt = '0;
          n_y   = '0;
          if (en) begin
            n_state = S_VSYNC;
            n_psel  = pattern_sel;
          end else begin
            n_state = S_IDLE;
          end
        end
      end
      default: begin
        n_state = S_IDLE;
        n_cnt   = '0;
      end
    endcase
  end

  // Pixel byte for the upcoming cycle: x is the byte index >> 1, byte index bit 0 picks the half.
  always_comb begin
    rgb  = 16'h0000;
    n_px = 8'h00;
    if (n_state == S_LINE) begin
      case (n_psel)
        2'd0:    rgb = {{5{n_cnt[7]}}, {6{n_cnt[6]}}, {5{n_cnt[5]}}};
        2'd1:    rgb = {n_cnt[5:1], n_y[5:0], 5'd0};
        2'd2:    rgb = (n_cnt[4] ^ n_y[3]) ? 16'hFFFF : 16'h0000;
        default: rgb = 16'h0000;
      endcase
      if (n_psel == 2'd3) n_px = n_cnt[0] ? ~frame_cnt_q : frame_cnt_q;
      else                n_px = n_cnt[0] ? rgb[7:0] : rgb[15:8];
    end
  end

  // State, counters and registered camera outputs.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      y              <= '0;
      psel           <= '0;
      frame_cnt_q    <= '0;
      cam.vsync      <= 1'b0;
      cam.href       <= 1'b0;
      cam.px_data    <= 8'h00;
      cam.frame_done <= 1'b0;
    end else begin
      state          <= n_state;
      cnt            <= n_cnt;
      y              <= n_y;
      psel           <= n_psel;
      cam.vsync      <= (n_state == S_VSYNC);
      cam.href       <= (n_state == S_LINE);
      cam.px_data    <= n_px;
      cam.frame_done <= n_last;
      if (n_last) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end
endmodule

// File: tb/tb_cam_stream_gen.sv
// tb/tb_cam_stream_gen.sv - testbench for cam_stream_gen
module tb_cam_stream_gen;
  localparam int SHA = 4, SVA = 2, SHB = 3, SVS = 1, SVB = 1, SVF = 1;
  localparam int SLP = 2 * SHA + SHB;
  localparam int SFL = (SVS + SVB + SVA + SVF) * SLP;
  localparam int DHA = 160, DVA = 120, DHB = 144, DVS = 3, DVB = 17, DVF = 10;
  localparam int DLP = 2 * DHA + DHB;
  localparam int DFL = (DVS + DVB + DVA + DVF) * DLP;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic       s_rst = 1'b1, s_en = 1'b0;
  logic [1:0] s_ps = 2'd0;
  logic       d_rst = 1'b1, d_en = 1'b0;
  logic [1:0] d_ps = 2'd0;

  cam_stream_gen_if s_if ();
  cam_stream_gen_if d_if ();

  cam_stream_gen #(.H_ACTIVE(SHA), .V_ACTIVE(SVA), .H_BLANK(SHB),
                   .VSYNC_LINES(SVS), .V_BACK(SVB), .V_FRONT(SVF)) u_small (
    .pclk(pclk), .rst(s_rst), .en(s_en), .pattern_sel(s_ps), .cam(s_if));

  cam_stream_gen #(.H_ACTIVE(DHA), .V_ACTIVE(DVA), .H_BLANK(DHB),
                   .VSYNC_LINES(DVS), .V_BACK(DVB), .V_FRONT(DVF)) u_dflt (
    .pclk(pclk), .rst(d_rst), .en(d_en), .pattern_sel(d_ps), .cam(d_if));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  // Reference: frame position t -> {vsync, href, byte}, from line/column arithmetic.
  function automatic logic [9:0] exp_vhp(input int ha, input int va, input int hb, input int vs,
                                         input int vb, input int t, input logic [1:0] ps,
                                         input logic [7:0] fid);
    int lp, line, col, l, x, ph, r, g, b, rgb;
    logic [7:0] px;
    lp = 2 * ha + hb;
    line = t / lp;
    col = t % lp;
    l = line - vs - vb;
    if (!(l >= 0 && l < va && col < 2 * ha))
      return {(line < vs) ? 1'b1 : 1'b0, 1'b0, 8'h00};
    x = col / 2;
    ph = col % 2;
    r = 0; g = 0; b = 0;
    case (ps)
      2'd0: begin
        r = ((x / 64) % 2 != 0) ? 31 : 0;
        g = ((x / 32) % 2 != 0) ? 63 : 0;
        b = ((x / 16) % 2 != 0) ? 31 : 0;
      end
      2'd1: begin r = x % 32; g = l % 64; end
      2'd2: if ((x / 8) % 2 != (l / 8) % 2) begin r = 31; g = 63; b = 31; end
      default: ;
    endcase
    rgb = r * 2048 + g * 32 + b;
    if (ps == 2'd3) px = (ph != 0) ? ~fid : fid;
    else            px = 8'((ph != 0) ? rgb % 256 : rgb / 256);
    return {1'b0, 1'b1, px};
  endfunction

  logic       s_act = 1'b0, s_chk = 1'b0;
  int         s_t = 0;
  logic [1:0] s_mps = 2'd0;
  logic [7:0] s_cnt = 8'd0;
  logic       d_act = 1'b0, d_chk = 1'b0;
  int         d_t = 0;
  logic [1:0] d_mps = 2'd0;
  logic [7:0] d_cnt = 8'd0;

  // Frame-level models: idle, or position t inside a frame of fixed length.
  always @(posedge pclk) begin
    if (s_rst) begin
      s_act <= 1'b0; s_t <= 0; s_cnt <= 8'd0;
    end else if (!s_act) begin
      if (s_en) begin s_act <= 1'b1; s_t <= 0; s_mps <= s_ps; end
    end else if (s_t == SFL - 1) begin
      if (s_en) begin s_t <= 0; s_mps <= s_ps; end
      else s_act <= 1'b0;
    end else begin
      s_t <= s_t + 1;
      if (s_t + 1 == SFL - 1) s_cnt <= s_cnt + 8'd1;
    end
  end

  always @(posedge pclk) begin
    if (d_rst) begin
      d_act <= 1'b0; d_t <= 0; d_cnt <= 8'd0;
    end else if (!d_act) begin
      if (d_en) begin d_act <= 1'b1; d_t <= 0; d_mps <= d_ps; end
    end else if (d_t == DFL - 1) begin
      if (d_en) begin d_t <= 0; d_mps <= d_ps; end
      else d_act <= 1'b0;
    end else begin
      d_t <= d_t + 1;
      if (d_t + 1 == DFL - 1) d_cnt <= d_cnt + 8'd1;
    end
  end

  always @(negedge pclk) begin
    if (s_chk) begin
      check("s_vhp", {s_if.vsync, s_if.href, s_if.px_data},
            s_act ? exp_vhp(SHA, SVA, SHB, SVS, SVB, s_t, s_mps, s_cnt) : 10'd0);
      check("s_done", s_if.frame_done, s_act && s_t == SFL - 1);
      check("s_fcnt", s_if.frame_cnt, s_cnt);
    end
    if (d_chk) begin
      check("d_vhp", {d_if.vsync, d_if.href, d_if.px_data},
            d_act ? exp_vhp(DHA, DVA, DHB, DVS, DVB, d_t, d_mps, d_cnt) : 10'd0);
      check("d_done", d_if.frame_done, d_act && d_t == DFL - 1);
      check("d_fcnt", d_if.frame_cnt, d_cnt);
    end
  end

  logic       rec_vs[2*SFL], rec_hr[2*SFL], rec_fd[2*SFL];
  logic [7:0] rec_px[2*SFL], rec_fc[2*SFL];
  logic [7:0] exp_t2[16] = '{8'h00, 8'h00, 8'h08, 8'h00, 8'h10, 8'h00, 8'h18, 8'h00,
                             8'h00, 8'h20, 8'h08, 8'h20, 8'h10, 8'h20, 8'h18, 8'h20};
  logic [7:0] bytes_q[$];
  logic [7:0] p1_q[$];
  logic [7:0] line0[320];
  int idx_t3[5]       = '{0, 16, 64, 112, 144};
  logic [15:0] exp_t3[5] = '{16'h0000, 16'h001F, 16'hF800, 16'hFFFF, 16'h001F};

  initial begin
    int vs_hi, rises, r1, f1, r2, fds, run, lines;
    tick(); tick();
    s_chk = 1'b1; d_chk = 1'b1;
    check("rst_out", {s_if.vsync, s_if.href, s_if.px_data, s_if.frame_done}, 0);
    check("rst_fcnt", s_if.frame_cnt, 0);

    // Small frame, pattern 1, two frames back to back.
    s_rst = 1'b0; s_en = 1'b1; s_ps = 2'd1;
    for (int i = 0; i < 2 * SFL; i++) begin
      tick();
      rec_vs[i] = s_if.vsync; rec_hr[i] = s_if.href; rec_fd[i] = s_if.frame_done;
      rec_px[i] = s_if.px_data; rec_fc[i] = s_if.frame_cnt;
    end
    vs_hi = 0; rises = 0; r1 = -1; f1 = -1; r2 = -1; fds = 0;
    for (int i = 0; i < SFL; i++) begin
      if (rec_vs[i]) vs_hi++;
      if (rec_hr[i]) bytes_q.push_back(rec_px[i]);
      if (i > 0 && rec_hr[i] && !rec_hr[i-1]) begin
        rises++;
        if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
      end
      if (i > 0 && !rec_hr[i] && rec_hr[i-1] && f1 < 0) f1 = i;
    end
    for (int i = 0; i < 2 * SFL; i++) if (rec_fd[i]) fds++;
    check("t1_vs_first", rec_vs[0], 1);
    check("t1_vs_len", vs_hi, 11);
    check("t1_href_pulses", rises, 2);
    check("t1_href_width", f1 - r1, 8);
    check("t1_href_gap", r2 - f1, 3);
    check("t1_done_count", fds, 2);
    check("t1_done_f0", rec_fd[54], 1);
    check("t1_done_f1", rec_fd[109], 1);
    check("t1_fcnt_pre", rec_fc[53], 0);
    check("t1_fcnt_1", rec_fc[54], 1);
    check("t1_fcnt_2", rec_fc[109], 2);
    check("t2_nbytes", bytes_q.size(), 16);
    for (int i = 0; i < 16 && i < bytes_q.size(); i++) check("t2_byte", bytes_q[i], exp_t2[i]);

    // Reset during an active line.
    for (int k = 0; k < 40; k++) begin
      if (s_if.href) break;
      tick();
    end
    check("t6_in_line", s_if.href, 1);
    s_rst = 1'b1;
    tick();
    check("t6_out", {s_if.vsync, s_if.href, s_if.px_data, s_if.frame_done}, 0);
    check("t6_fcnt", s_if.frame_cnt, 0);

    // Pattern 3, pattern_sel changed mid third frame, en dropped in the fourth.
    s_ps = 2'd3; s_en = 1'b1;
    tick();
    s_rst = 1'b0;
    bytes_q.delete();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < SFL; i++) begin
        tick();
        if (f == 2 && s_if.href) bytes_q.push_back(s_if.px_data);
        if (f == 3 && s_if.href) p1_q.push_back(s_if.px_data);
        if (f == 2 && i == 20) s_ps = 2'd1;
        if (f == 3 && i == 30) s_en = 1'b0;
        if (f == 3 && i == SFL - 1) check("t5_done", s_if.frame_done, 1);
      end
    end
    check("t4_nbytes", bytes_q.size(), 16);
    for (int i = 0; i < bytes_q.size(); i++)
      check("t4_byte", bytes_q[i], (i % 2 == 0) ? 8'h02 : 8'hFD);
    check("t4_next_nbytes", p1_q.size(), 16);
    if (p1_q.size() > 2) check("t4_next_px1", p1_q[2], 8'h08);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_idle", {s_if.vsync, s_if.href, s_if.px_data, s_if.frame_done}, 0);
      check("t5_fcnt", s_if.frame_cnt, 4);
    end
    s_en = 1'b1;
    tick();
    check("t5_restart", s_if.vsync, 1);

    // Random en / pattern_sel / occasional reset, checked by the model each cycle.
    for (int n = 0; n < 2000; n++) begin
      tick();
      if ($urandom_range(0, 7) == 0) s_ps = 2'($urandom);
      if ($urandom_range(0, 99) == 0) s_en = ~s_en;
      s_rst = ($urandom_range(0, 499) == 0);
    end
    s_rst = 1'b1;
    tick();

    // Default geometry, pattern 0, single frame.
    d_rst = 1'b0; d_en = 1'b1; d_ps = 2'd0;
    run = 0; lines = 0;
    for (int i = 0; i < DFL + 4; i++) begin
      tick();
      if (i == 0) d_en = 1'b0;
      if (d_if.href) begin
        if (lines == 0 && run < 320) line0[run] = d_if.px_data;
        run++;
      end else if (run != 0) begin
        check("t3_line_len", run, 320);
        lines++;
        run = 0;
      end
    end
    check("t3_lines", lines, 120);
    for (int k = 0; k < 5; k++)
      check("t3_bar_px", {line0[2*idx_t3[k]], line0[2*idx_t3[k]+1]}, exp_t3[k]);
    check("t3_idle_after", {d_if.vsync, d_if.href, d_if.frame_done}, 0);
    check("t3_fcnt", d_if.frame_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
